// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: decode-stage operand bypass select, load-use stall and
// long-latency writeback scoreboard. Forward selects, stall and ready are
// combinational from the decode inputs and registered slot state; only the
// scoreboard and the stall counter hold state.
module hazard_forward_unit #(
    parameter int unsigned NUM_FWD        = 2,
    parameter int unsigned LL_SLOTS       = 2,
    parameter int unsigned LL_LAT_W       = 4,
    parameter int unsigned SEL_W          = $clog2(NUM_FWD + 1),
    // Turn off to let a bench drive deliberate issue-while-busy violations.
    parameter bit          CHECK_PROTOCOL = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [6:0]             i_id_opcode,
    input  logic [4:0]             i_id_rs1,
    input  logic [4:0]             i_id_rs2,
    input  logic [NUM_FWD-1:0]     i_fwd_reg_write,
    input  logic [5*NUM_FWD-1:0]   i_fwd_rd,
    input  logic [NUM_FWD-1:0]     i_fwd_data_ok,
    input  logic                   i_ll_issue,
    input  logic [4:0]             i_ll_rd,
    input  logic [LL_LAT_W-1:0]    i_ll_lat,
    output logic [SEL_W-1:0]       o_fwd_sel_a,
    output logic [SEL_W-1:0]       o_fwd_sel_b,
    output logic                   o_stall,
    output logic                   o_ll_ready,
    output logic [31:0]            o_stall_cnt
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned CNT_W = 32;

    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    // PIM ops live in the custom-0 opcode space.
    localparam logic [OPC_W-1:0] OPC_PIM    = 7'b0001011;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [LL_SLOTS-1:0]                slot_valid;
    logic [LL_SLOTS-1:0][REG_W-1:0]     slot_rd;
    logic [LL_SLOTS-1:0][LL_LAT_W-1:0]  slot_cnt;
    logic [CNT_W-1:0]                   stall_cnt;

    logic                               use_rs1;
    logic                               use_rs2;
    logic [1:0][REG_W-1:0]              src_rs;
    logic [1:0]                         src_used;
    logic [1:0][SEL_W-1:0]              src_sel;
    logic [1:0]                         src_lu;
    logic [1:0]                         src_ll;
    logic [LL_SLOTS-1:0]                alloc_mask;
    logic                               any_free;
    logic                               waw_hit;
    logic                               alloc;
    logic                               stall;

    // Which source registers the decoded instruction actually reads.
    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (i_id_opcode)
            OPC_JAL, OPC_LUI, OPC_AUIPC: use_rs1 = 1'b0;
            default:                     use_rs1 = 1'b1;
        endcase
        case (i_id_opcode)
            OPC_R, OPC_STORE, OPC_BRANCH, OPC_PIM: use_rs2 = 1'b1;
            default:                               use_rs2 = 1'b0;
        endcase
    end

    assign src_rs   = {i_id_rs2, i_id_rs1};
    assign src_used = {use_rs2, use_rs1};

    // Per-source bypass pick (youngest stage wins), load-use and LL hazard.
    always_comb begin
        src_sel = '0;
        src_lu  = '0;
        src_ll  = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            if (src_used[s] && (src_rs[s] != '0)) begin
                // Walk oldest to youngest so the youngest match is the last write.
                for (int unsigned k = NUM_FWD; k > 0; k--) begin
                    if (i_fwd_reg_write[k-1] &&
                        (i_fwd_rd[REG_W*(k-1) +: REG_W] == src_rs[s])) begin
                        src_sel[s] = SEL_W'(k);
                        src_lu[s]  = ~i_fwd_data_ok[k-1];
                    end
                end
                for (int unsigned j = 0; j < LL_SLOTS; j++) begin
                    if (slot_valid[j] && (slot_rd[j] == src_rs[s])) begin
                        src_ll[s] = 1'b1;
                    end
                end
            end
        end
    end

    // Lowest free slot and WAW check against in-flight long-latency writes.
    always_comb begin
        alloc_mask = '0;
        any_free   = 1'b0;
        waw_hit    = 1'b0;
        for (int unsigned j = 0; j < LL_SLOTS; j++) begin
            if (!slot_valid[j] && !any_free) begin
                alloc_mask[j] = 1'b1;
                any_free      = 1'b1;
            end
            if (slot_valid[j] && (slot_rd[j] == i_ll_rd)) begin
                waw_hit = 1'b1;
            end
        end
    end

    assign o_ll_ready  = any_free & ~waw_hit;
    assign alloc       = i_ll_issue & o_ll_ready & (i_ll_rd != '0);
    assign stall       = ~i_rst & ((|src_lu) | (|src_ll));
    assign o_stall     = stall;
    assign o_fwd_sel_a = i_rst ? '0 : src_sel[0];
    assign o_fwd_sel_b = i_rst ? '0 : src_sel[1];
    assign o_stall_cnt = stall_cnt;

    // Scoreboard slots: count down every cycle, retire on 1->0, load on issue.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slot_valid <= '0;
            slot_rd    <= '0;
            slot_cnt   <= '0;
        end else begin
            for (int unsigned j = 0; j < LL_SLOTS; j++) begin
                if (slot_valid[j]) begin
                    slot_cnt[j] <= slot_cnt[j] - LL_LAT_W'(1);
                    if (slot_cnt[j] == LL_LAT_W'(1)) begin
                        slot_valid[j] <= 1'b0;
                    end
                end
                if (alloc && alloc_mask[j]) begin
                    slot_valid[j] <= 1'b1;
                    slot_rd[j]    <= i_ll_rd;
                    slot_cnt[j]   <= i_ll_lat;
                end
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // An issue presented while the scoreboard is busy is a producer bug.
    generate
        if (CHECK_PROTOCOL) begin : g_protocol
            a_issue_when_ready: assert property (
                @(posedge i_clk) disable iff (i_rst) i_ll_issue |-> o_ll_ready
            ) else $error("long-latency issue presented while not ready");
        end
    endgenerate

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios plus random traffic,
// expected values from a pending-write model, compared by a negedge monitor.
module tb_hazard_forward_unit;

    localparam int unsigned NUM_FWD  = 2;
    localparam int unsigned LL_SLOTS = 2;
    localparam int unsigned LL_LAT_W = 4;
    localparam int unsigned SEL_W    = 2;

    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_PIM    = 7'h0B;
    localparam logic [6:0] OP_ADDI   = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;

    logic                  clk;
    logic                  i_rst;
    logic [6:0]            i_id_opcode;
    logic [4:0]            i_id_rs1;
    logic [4:0]            i_id_rs2;
    logic [NUM_FWD-1:0]    i_fwd_reg_write;
    logic [5*NUM_FWD-1:0]  i_fwd_rd;
    logic [NUM_FWD-1:0]    i_fwd_data_ok;
    logic                  i_ll_issue;
    logic [4:0]            i_ll_rd;
    logic [LL_LAT_W-1:0]   i_ll_lat;
    logic [SEL_W-1:0]      o_fwd_sel_a;
    logic [SEL_W-1:0]      o_fwd_sel_b;
    logic                  o_stall;
    logic                  o_ll_ready;
    logic [31:0]           o_stall_cnt;

    hazard_forward_unit #(
        .NUM_FWD(NUM_FWD), .LL_SLOTS(LL_SLOTS), .LL_LAT_W(LL_LAT_W),
        .SEL_W(SEL_W), .CHECK_PROTOCOL(1'b0)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_id_opcode(i_id_opcode), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_fwd_reg_write(i_fwd_reg_write), .i_fwd_rd(i_fwd_rd),
        .i_fwd_data_ok(i_fwd_data_ok),
        .i_ll_issue(i_ll_issue), .i_ll_rd(i_ll_rd), .i_ll_lat(i_ll_lat),
        .o_fwd_sel_a(o_fwd_sel_a), .o_fwd_sel_b(o_fwd_sel_b),
        .o_stall(o_stall), .o_ll_ready(o_ll_ready), .o_stall_cnt(o_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [SEL_W-1:0] sel_a;
        logic [SEL_W-1:0] sel_b;
        logic             stall;
        logic             ready;
        logic [31:0]      cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Model: each pending write is just (rd, cycle at which it is no longer pending).
    int unsigned cyc   = 0;
    logic [31:0] m_cnt = '0;
    logic [4:0]  pend_rd[$];
    int unsigned pend_free[$];

    function automatic bit uses_rs1(input logic [6:0] op);
        return !(op == OP_JAL || op == OP_LUI || op == OP_AUIPC);
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return (op == OP_R || op == OP_STORE || op == OP_BRANCH || op == OP_PIM);
    endfunction

    function automatic int pick(input logic [4:0] rs, input bit used,
                                input logic [1:0] we, input logic [4:0] rd0,
                                input logic [4:0] rd1);
        if (!used || rs == 5'd0) return 0;
        if (we[0] && rd0 == rs) return 1;
        if (we[1] && rd1 == rs) return 2;
        return 0;
    endfunction

    function automatic bit pending(input logic [4:0] r);
        foreach (pend_rd[i]) if (pend_rd[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one decode cycle, queue its expected response, then advance the model.
    task automatic step(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [1:0] we, input logic [4:0] rd0, input logic [4:0] rd1,
                        input logic [1:0] ok, input logic iss, input logic [4:0] lrd,
                        input logic [3:0] lat, input logic rst);
        exp_t e;
        int   sa;
        int   sb;
        bit   lu;
        bit   ll;
        bit   acc;
        i_rst           = rst;
        i_id_opcode     = op;
        i_id_rs1        = rs1;
        i_id_rs2        = rs2;
        i_fwd_reg_write = we;
        i_fwd_rd        = {rd1, rd0};
        i_fwd_data_ok   = ok;
        i_ll_issue      = iss;
        i_ll_rd         = lrd;
        i_ll_lat        = lat;
        sa  = pick(rs1, uses_rs1(op), we, rd0, rd1);
        sb  = pick(rs2, uses_rs2(op), we, rd0, rd1);
        lu  = (sa != 0 && !ok[sa-1]) || (sb != 0 && !ok[sb-1]);
        ll  = (uses_rs1(op) && rs1 != 5'd0 && pending(rs1)) ||
              (uses_rs2(op) && rs2 != 5'd0 && pending(rs2));
        acc = 1'b0;
        if (rst) begin
            e.sel_a = '0; e.sel_b = '0; e.stall = 1'b0; e.ready = 1'b1; e.cnt = '0;
        end else begin
            e.sel_a = SEL_W'(sa);
            e.sel_b = SEL_W'(sb);
            e.stall = lu || ll;
            e.ready = (pend_rd.size() < int'(LL_SLOTS)) && !pending(lrd);
            e.cnt   = m_cnt;
            acc     = iss && e.ready && (lrd != 5'd0);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            pend_rd.delete();
            pend_free.delete();
            m_cnt = '0;
        end else begin
            if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (acc) begin
                pend_rd.push_back(lrd);
                pend_free.push_back(cyc + 32'(lat) + 1);
            end
        end
        cyc = cyc + 1;
        for (int i = pend_rd.size() - 1; i >= 0; i--) begin
            if (pend_free[i] <= cyc) begin
                pend_rd.delete(i);
                pend_free.delete(i);
            end
        end
    endtask

    task automatic dec(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [1:0] we, input logic [4:0] rd0, input logic [4:0] rd1,
                       input logic [1:0] ok);
        step(op, rs1, rs2, we, rd0, rd1, ok, 1'b0, 5'd0, 4'd0, 1'b0);
    endtask

    task automatic issue(input logic [4:0] lrd, input logic [3:0] lat);
        step(OP_ADDI, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11, 1'b1, lrd, lat, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: the unit presents a response every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sel_a",     32'(o_fwd_sel_a), 32'(e.sel_a));
                chk("sel_b",     32'(o_fwd_sel_b), 32'(e.sel_b));
                chk("stall",     32'(o_stall),     32'(e.stall));
                chk("ll_ready",  32'(o_ll_ready),  32'(e.ready));
                chk("stall_cnt", o_stall_cnt,      e.cnt);
            end
        end
    end

    logic [6:0] ops[9];

    initial begin
        ops = '{OP_JAL, OP_LUI, OP_AUIPC, OP_R, OP_STORE, OP_BRANCH, OP_PIM, OP_ADDI, OP_LOAD};
        i_rst = 1'b1; i_id_opcode = '0; i_id_rs1 = '0; i_id_rs2 = '0;
        i_fwd_reg_write = '0; i_fwd_rd = '0; i_fwd_data_ok = '0;
        i_ll_issue = 1'b0; i_ll_rd = '0; i_ll_lat = '0;
        @(posedge clk);
        #1;
        step(OP_ADDI, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 4'd0, 1'b1);

        // Youngest stage wins when both match.
        dec(OP_R, 5'd5, 5'd5, 2'b11, 5'd5, 5'd5, 2'b11);
        // Unused sources never forward.
        dec(OP_LUI, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b11);
        dec(OP_ADDI, 5'd0, 5'd5, 2'b01, 5'd5, 5'd0, 2'b11);
        // Older stage only.
        dec(OP_STORE, 5'd6, 5'd6, 2'b10, 5'd0, 5'd6, 2'b11);
        // x0 never matches.
        dec(OP_R, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 2'b00);
        // Load-use on rs2, then data arrives.
        dec(OP_BRANCH, 5'd0, 5'd7, 2'b01, 5'd7, 5'd0, 2'b10);
        dec(OP_BRANCH, 5'd0, 5'd7, 2'b01, 5'd7, 5'd0, 2'b11);

        // Long-latency hazard window.
        issue(5'd9, 4'd3);
        repeat (4) dec(OP_R, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11);

        // Fill the scoreboard, violate, then re-issue a busy rd.
        issue(5'd3, 4'd5);
        issue(5'd4, 4'd5);
        issue(5'd6, 4'd5);
        dec(OP_PIM, 5'd6, 5'd4, 2'b00, 5'd0, 5'd0, 2'b11);
        repeat (7) issue(5'd3, 4'd5);
        repeat (6) dec(OP_R, 5'd3, 5'd4, 2'b00, 5'd0, 5'd0, 2'b11);

        // Reset with two writes pending.
        issue(5'd10, 4'd9);
        issue(5'd11, 4'd9);
        dec(OP_R, 5'd10, 5'd11, 2'b00, 5'd0, 5'd0, 2'b11);
        step(OP_R, 5'd10, 5'd11, 2'b01, 5'd10, 5'd0, 2'b00, 1'b0, 5'd0, 4'd0, 1'b1);
        dec(OP_R, 5'd10, 5'd11, 2'b00, 5'd0, 5'd0, 2'b11);

        // Random traffic over a small register window to force collisions.
        for (int n = 0; n < 1500; n++) begin
            step(ops[$urandom_range(0, 8)],
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 7)), 4'($urandom_range(1, 6)),
                 1'($urandom_range(0, 99) == 0));
        end

        @(negedge clk);
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d expected=0 pending responses", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised decode-stage hazard unit. Supersedes the fixed single-stage WB forwarding unit.
- Selects operand bypass from NUM_FWD stages, youngest first.
- Generates load-use stalls.
- Tracks long-latency writebacks (PIM, mul/div) in a countdown scoreboard of LL_SLOTS entries.
- Sits between decode and execute. Drives the operand muxes and the pipeline stall line.

Parameters:
- NUM_FWD, 2, number of bypass stages. Index 0 is the youngest (MEM); index NUM_FWD-1 is WB.
- LL_SLOTS, 2, number of concurrent in-flight long-latency writes tracked.
- LL_LAT_W, 4, width of the long-latency count. Maximum latency is 2^LL_LAT_W-1.
- SEL_W, $clog2(NUM_FWD+1), width of the forward select.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_id_opcode  in  7  decode-stage opcode
- i_id_rs1  in  5  source register 1
- i_id_rs2  in  5  source register 2
- i_fwd_reg_write  in  NUM_FWD  per-stage write enable
- i_fwd_rd  in  5*NUM_FWD  per-stage destination; stage k occupies bits [5k+4:5k]
- i_fwd_data_ok  in  NUM_FWD  stage result available; 0 for a load still in MEM
- i_ll_issue  in  1  long-latency op leaves execute this cycle
- i_ll_rd  in  5  long-latency destination
- i_ll_lat  in  LL_LAT_W  cycles until the RF write completes (1..max)
- o_fwd_sel_a  out  SEL_W  0 = RF; k+1 = stage k
- o_fwd_sel_b  out  SEL_W  same encoding as o_fwd_sel_a
- o_stall  out  1  hold IF/ID and insert a bubble into EX
- o_ll_ready  out  1  scoreboard can accept an issue
- o_stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Reset values, asynchronous on i_rst:
  - all slots invalid, all counts 0
  - o_stall_cnt = 0
  - o_stall = 0, o_fwd_sel_a/b = 0, o_ll_ready = 1
- A reset asserted mid-operation drops all pending slots immediately.
- Source use:
  - rs1 is used unless the opcode is JAL, LUI or AUIPC.
  - rs2 is used only for R, STORE, BRANCH and PIM.
  - An unused source gives sel = 0 and cannot cause a stall.
- Register x0 never matches, as either a source or a destination.
- Forwarding is combinational, zero latency.
  - For each used source, pick the lowest k with i_fwd_reg_write[k] and rd[k] == rs. Then sel = k+1; if there is no match, sel = 0.
  - Youngest wins. Older stages are ignored once a younger stage matches.
- Load-use stall: the selected stage k has i_fwd_data_ok[k] = 0. The select value is still driven.
- Scoreboard:
  - Each slot holds {valid, rd, cnt}.
  - On i_ll_issue with o_ll_ready = 1, the lowest-index invalid slot loads {1, i_ll_rd, i_ll_lat} at the clock edge.
  - Each valid slot decrements cnt every cycle, independent of o_stall.
  - A slot goes invalid on the edge where cnt goes 1->0. The issuer guarantees the RF write lands on that same edge, so no bypass is needed afterwards.
  - A slot that expires this cycle cannot be reallocated in the same cycle. Free slots are judged from registered state only.
  - i_ll_issue with i_ll_rd = x0 allocates nothing.
- LL stall: a used source matches the rd of a valid slot.
- o_stall = load-use stall OR LL stall. It is combinational from the inputs and registered slot state.
- o_ll_ready = (some slot is invalid) AND (no valid slot has rd == i_ll_rd). This blocks WAW between long-latency ops.
  - Issuing while o_ll_ready = 0 is a protocol error. The issue is ignored with no state change, and an assertion flags it.
- Simultaneous events in one cycle:
  - issue plus expiry plus decode match: the decode check uses pre-edge state.
  - A new issue does not affect o_stall until the next cycle.
- o_stall_cnt increments each cycle o_stall = 1 and saturates at 0xFFFF_FFFF.

Test Plan:
- R-type with rs1 = rs2 = 5; stage0 and stage1 both write rd 5, data_ok = 11 -> sel_a = sel_b = 1, stall = 0.
- LUI with rs1 = 5 and stage0 writing 5; separately, ADDI with rs2 = 5 -> sel_a = 0 (LUI), sel_b = 0 (ADDI), no stall.
- Load in stage0 with rd 7, data_ok[0] = 0; BRANCH with rs2 = 7 -> stall = 1, sel_b = 1. Raise data_ok -> stall = 0 the same cycle; o_stall_cnt = 1.
- Issue LL rd 9, lat 3 at cycle t; ADD rs1 = 9 presented from t+1 -> stall during t+1..t+3, clear at t+4; the slot is free at t+4.
- Fill both slots (rd 3 and 4, lat 5) -> o_ll_ready = 0. Issue rd 6 anyway -> ignored. Issue rd 3 after a slot frees -> accepted only once the rd-3 slot has expired.
- Assert i_rst with two slots pending -> all slots invalid, o_stall = 0, o_stall_cnt = 0 immediately without waiting for a clock; dependent sources no longer stall.
